// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

    localparam int unsigned STALL_W_DEF    = 6;
    localparam int unsigned MD_TIMEOUT_DEF = 64;
    localparam int unsigned CNT_W_DEF      = 32;
    localparam int unsigned WD_W           = 8;

    // StallBus bit order: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_LOADUSE = 6'b000111;
    localparam logic [5:0] STALL_MDBUSY  = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } md_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_md_watchdog.sv
// Cycle watchdog for the mul/div unit: counts while enabled, flags the last
// allowed cycle so the sequencer can abort on the following edge.
module pipe_stall_ctrl_md_watchdog
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned TC = MD_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [WD_W-1:0] cnt_q;

    // Up-counter with synchronous clear; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + WD_W'(1);
        end
    end

    assign tc_o = (cnt_q == WD_W'(TC - 1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: merges load-use and mul/div stall requests
// onto the StallBus, runs the mul/div start/ready handshake with a watchdog
// and flush abort, and counts stalled cycles.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no mul/div in flight; load-use stalls pass through
//   ST_START | md_start pulse is out; md_ready ignored this cycle
//   ST_BUSY  | waiting for md_ready; watchdog running
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned STALL_W    = STALL_W_DEF,
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               md_req,
    input  logic               md_ready,
    input  logic               flush,
    output logic [STALL_W-1:0] stall,
    output logic               md_start,
    output logic               md_abort,
    output logic               md_timeout,
    output logic [CNT_W-1:0]   stall_cnt
);

    md_state_t        state_q;
    logic             md_start_q;
    logic             md_abort_q;
    logic             md_timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [5:0]       stall_pat;
    logic             wd_tc;

    // Watchdog only runs in BUSY; any other state holds it at zero, so it
    // starts from zero on every entry to BUSY.
    pipe_stall_ctrl_md_watchdog #(
        .TC (MD_TIMEOUT)
    ) u_md_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != ST_BUSY),
        .en_i  (state_q == ST_BUSY),
        .tc_o  (wd_tc)
    );

    // Stall pattern: flush beats everything, then mul/div, then load-use.
    always_comb begin
        stall_pat = STALL_NONE;
        if (!flush) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (md_req) begin
                        stall_pat = STALL_MDBUSY;
                    end else if (stallreq_id) begin
                        stall_pat = STALL_LOADUSE;
                    end
                end
                ST_START: stall_pat = STALL_MDBUSY;
                ST_BUSY:  stall_pat = md_ready ? STALL_NONE : STALL_MDBUSY;
                default:  stall_pat = STALL_NONE;
            endcase
        end
    end

    // Mul/div sequencer with registered start/abort pulses and sticky timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            md_start_q   <= 1'b0;
            md_abort_q   <= 1'b0;
            md_timeout_q <= 1'b0;
        end else begin
            md_start_q <= 1'b0;
            md_abort_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (md_req && !flush) begin
                        state_q    <= ST_START;
                        md_start_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (flush) begin
                        state_q    <= ST_IDLE;
                        md_abort_q <= 1'b1;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        state_q    <= ST_IDLE;
                        md_abort_q <= 1'b1;
                    end else if (md_ready) begin
                        state_q <= ST_IDLE;
                    end else if (wd_tc) begin
                        // Give up on the unit; the pipeline resumes with an
                        // undefined result and software sees md_timeout.
                        state_q      <= ST_IDLE;
                        md_abort_q   <= 1'b1;
                        md_timeout_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Free-running count of stalled cycles; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_pat != STALL_NONE) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall      = STALL_W'(stall_pat);
    assign md_start   = md_start_q;
    assign md_abort   = md_abort_q;
    assign md_timeout = md_timeout_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vector table, hand-written corner
// sequences, then random traffic against a reference model.
module tb_pipe_stall_ctrl;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stallreq_id;
    logic          md_req;
    logic          md_ready;
    logic          flush;
    logic [5:0]    stall;
    logic          md_start;
    logic          md_abort;
    logic          md_timeout;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         rst;
        bit         sr;
        bit         mr;
        bit         rdy;
        bit         fl;
        logic [5:0] stall;
        bit         start;
        bit         abort;
        bit         tout;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    // Reference model: an in-flight flag plus the age of the operation in
    // cycles since it was accepted (age 1 = start pulse cycle).
    bit m_active = 0;
    int m_age    = 0;
    bit m_abort  = 0;
    bit m_to     = 0;
    int m_cnt    = 0;

    pipe_stall_ctrl #(
        .STALL_W    (6),
        .MD_TIMEOUT (T),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .md_req      (md_req),
        .md_ready    (md_ready),
        .flush       (flush),
        .stall       (stall),
        .md_start    (md_start),
        .md_abort    (md_abort),
        .md_timeout  (md_timeout),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit sr, bit mr, bit rdy, bit fl,
                                logic [5:0] st, bit s, bit a, bit t, int c);
        vec_t v;
        v.rst = r; v.sr = sr; v.mr = mr; v.rdy = rdy; v.fl = fl;
        v.stall = st; v.start = s; v.abort = a; v.tout = t; v.cnt = c;
        return v;
    endfunction

    function automatic logic [5:0] m_stall(bit sr, bit mr, bit rdy, bit fl);
        if (fl) return 6'b000000;
        if (!m_active) return mr ? 6'b001111 : (sr ? 6'b000111 : 6'b000000);
        if (m_age == 1) return 6'b001111;
        return rdy ? 6'b000000 : 6'b001111;
    endfunction

    task automatic m_update(input vec_t v);
        if (!v.rst) begin
            m_active = 0; m_age = 0; m_abort = 0; m_to = 0; m_cnt = 0;
        end else begin
            if (m_stall(v.sr, v.mr, v.rdy, v.fl) != 6'b0) m_cnt = (m_cnt + 1) % (1 << CW);
            m_abort = 0;
            if (m_active) begin
                if (v.fl) begin
                    m_active = 0; m_abort = 1;
                end else if (m_age >= 2 && v.rdy) begin
                    m_active = 0;
                end else if (m_age == int'(T) + 1) begin
                    m_active = 0; m_abort = 1; m_to = 1;
                end else begin
                    m_age++;
                end
            end else if (v.mr && !v.fl) begin
                m_active = 1; m_age = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic run_cycle(input vec_t v, input bit use_model);
        vec_t e;
        e = v;
        if (use_model) begin
            e.stall = m_stall(v.sr, v.mr, v.rdy, v.fl);
            e.start = m_active && (m_age == 1);
            e.abort = m_abort;
            e.tout  = m_to;
            e.cnt   = m_cnt;
        end
        rst = v.rst; stallreq_id = v.sr; md_req = v.mr; md_ready = v.rdy; flush = v.fl;
        @(negedge clk);
        chk("stall",      32'(stall),      32'(e.stall));
        chk("md_start",   32'(md_start),   32'(e.start));
        chk("md_abort",   32'(md_abort),   32'(e.abort));
        chk("md_timeout", 32'(md_timeout), 32'(e.tout));
        chk("stall_cnt",  32'(stall_cnt),  32'(e.cnt));
        @(posedge clk);
        m_update(v);
        #1;
    endtask

    initial begin
        vec_t v;
        // reset held with every input high, then release
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,1,1, 6'h00,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,0,0,0));
        // single load-use stall
        tbl.push_back(mk(1,1,0,0,0, 6'h07,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,0,0,1));
        // normal mul/div, ready at t4, then back-to-back request
        tbl.push_back(mk(1,0,1,0,0, 6'h0F,0,0,0,1));
        tbl.push_back(mk(1,0,1,0,0, 6'h0F,1,0,0,2));
        tbl.push_back(mk(1,0,1,0,0, 6'h0F,0,0,0,3));
        tbl.push_back(mk(1,0,1,0,0, 6'h0F,0,0,0,4));
        tbl.push_back(mk(1,0,1,1,0, 6'h00,0,0,0,5));
        tbl.push_back(mk(1,0,1,0,0, 6'h0F,0,0,0,5));
        tbl.push_back(mk(1,0,1,0,0, 6'h0F,1,0,0,6));
        tbl.push_back(mk(1,0,1,1,0, 6'h00,0,0,0,7));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,0,0,7));
        // md_req beats load-use; flush in BUSY releases and aborts
        tbl.push_back(mk(1,1,1,0,0, 6'h0F,0,0,0,7));
        tbl.push_back(mk(1,1,1,0,0, 6'h0F,1,0,0,8));
        tbl.push_back(mk(1,1,1,0,1, 6'h00,0,0,0,9));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,1,0,9));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,0,0,9));
        // flush with md_req in IDLE: nothing starts, nothing aborts
        tbl.push_back(mk(1,0,1,0,1, 6'h00,0,0,0,9));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,0,0,9));
        // flush during START
        tbl.push_back(mk(1,0,1,0,0, 6'h0F,0,0,0,9));
        tbl.push_back(mk(1,0,1,0,1, 6'h00,1,0,0,10));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,1,0,10));
        tbl.push_back(mk(1,1,0,0,0, 6'h07,0,0,0,10));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,0,0,11));
        // md_ready during START is ignored
        tbl.push_back(mk(1,0,1,0,0, 6'h0F,0,0,0,11));
        tbl.push_back(mk(1,0,1,1,0, 6'h0F,1,0,0,12));
        tbl.push_back(mk(1,0,1,1,0, 6'h00,0,0,0,13));
        tbl.push_back(mk(1,0,0,0,0, 6'h00,0,0,0,13));

        rst = 1'b0; stallreq_id = 1'b0; md_req = 1'b0; md_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_cycle(tbl[i], 0);

        // watchdog timeout: abort and sticky flag six cycles after request
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,13), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,1,0,0,14), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,15), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,0), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,1), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,2), 0);
        run_cycle(mk(1,0,0,0,0, 6'h00,0,1,1,3), 0);
        run_cycle(mk(1,0,0,0,0, 6'h00,0,0,1,3), 0);

        // reset clears the sticky flag; 17 stalled cycles wrap a 4-bit count
        run_cycle(mk(0,0,0,0,0, 6'h00,0,0,1,3), 0);
        for (int i = 0; i < 17; i++) run_cycle(mk(1,1,0,0,0, 6'h07,0,0,0,i % 16), 0);
        run_cycle(mk(1,0,0,0,0, 6'h00,0,0,0,1), 0);

        // md_ready on the watchdog's terminal cycle: ready wins
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,1), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,1,0,0,2), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,3), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,4), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,5), 0);
        run_cycle(mk(1,0,1,1,0, 6'h00,0,0,0,6), 0);
        run_cycle(mk(1,0,0,0,0, 6'h00,0,0,0,6), 0);
        run_cycle(mk(1,0,0,0,0, 6'h00,0,0,0,6), 0);

        // reset mid-sequence: back to idle, no abort
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,6), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,1,0,0,7), 0);
        run_cycle(mk(1,0,1,0,0, 6'h0F,0,0,0,8), 0);
        run_cycle(mk(0,0,1,0,0, 6'h0F,0,0,0,9), 0);
        run_cycle(mk(1,0,0,0,0, 6'h00,0,0,0,0), 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            v = mk(1,0,0,0,0, 6'h00,0,0,0,0);
            v.rst = ($urandom_range(0, 99) != 0);
            v.sr  = ($urandom_range(0, 3) == 0);
            v.mr  = ($urandom_range(0, 1) == 0);
            v.rdy = ($urandom_range(0, 5) == 0);
            v.fl  = ($urandom_range(0, 11) == 0);
            run_cycle(v, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
